aes_ctr_keystream_seq: RTL

- CTR-mode sequencer placed directly upstream of the AES block-cipher core in the scannable AES-CTR peripheral.
- Accepts 128-bit plaintext blocks on a valid/ready stream and holds the 128-bit counter block.
- For each block it issues the counter to the core, waits for the core's done, XORs the returned keystream with the plaintext, and emits ciphertext on an output stream.
- Maintains the counter increment, block count and a watchdog on core completion.

---
 rtl/aes_ctr_keystream_seq.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/aes_ctr_keystream_seq.sv
// CTR-mode sequencer in front of the AES core: issues the counter block, XORs the
// returned keystream with the plaintext and streams out ciphertext.
module aes_ctr_keystream_seq #(
  parameter int unsigned CTR_WIDTH      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic [127:0]         iv,
  input  logic                 iv_load,
  input  logic [1:0]           key_sel_in,
  input  logic                 clear_err,
  input  logic [127:0]         s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic                 s_last,
  output logic [127:0]         m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last,
  output logic                 core_start,
  output logic [127:0]         core_block,
  output logic [1:0]           core_key_sel,
  input  logic                 core_done,
  input  logic [127:0]         core_result,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] blk_count,
  output logic [1:0]           err
);

  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [127:0] CTR_MASK = (CTR_WIDTH >= 128) ? {128{1'b1}}
                                    : ((128'(1) << CTR_WIDTH) - 128'(1));

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_e;

  state_e                 state_q, state_d;
  logic [127:0]           ctr_q, ctr_d;
  logic [127:0]           pt_q, pt_d;
  logic                   last_q, last_d;
  logic [1:0]             ksel_q, ksel_d;
  logic [127:0]           blk_q, blk_d;
  logic [WD_W-1:0]        wdog_q, wdog_d;
  logic [127:0]           mdata_q, mdata_d;
  logic                   mlast_q, mlast_d;
  logic                   mvalid_q, mvalid_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [1:0]             err_q, err_d;
  logic                   rdy_q, rdy_d;
  logic [127:0]           ctr_inc;

  // Only the low CTR_WIDTH bits count; the carry never reaches the fixed upper bits.
  assign ctr_inc = (ctr_q & ~CTR_MASK) | ((ctr_q + 128'(1)) & CTR_MASK);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    ctr_d    = ctr_q;
    pt_d     = pt_q;
    last_d   = last_q;
    ksel_d   = ksel_q;
    blk_d    = blk_q;
    wdog_d   = wdog_q;
    mdata_d  = mdata_q;
    mlast_d  = mlast_q;
    mvalid_d = mvalid_q;
    cnt_d    = cnt_q;
    err_d    = clear_err ? 2'b00 : err_q;
    case (state_q)
      IDLE: begin
        if (iv_load) begin
          ctr_d = iv;
          cnt_d = '0;
        end else if (s_valid && rdy_q) begin
          pt_d    = s_data;
          last_d  = s_last;
          ksel_d  = key_sel_in;
          blk_d   = ctr_q;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        wdog_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A done landing on the threshold cycle still wins over the timeout.
        if (core_done) begin
          mdata_d  = pt_q ^ core_result;
          mlast_d  = last_q;
          mvalid_d = 1'b1;
          ctr_d    = ctr_inc;
          state_d  = OUT;
        end else if (wdog_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          err_d[0] = 1'b1;
          state_d  = IDLE;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      OUT: begin
        if (m_ready) begin
          mvalid_d = 1'b0;
          cnt_d    = cnt_q + CNT_WIDTH'(1);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (iv_load && (state_q != IDLE)) err_d[1] = 1'b1;
    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      ctr_q    <= '0;
      pt_q     <= '0;
      last_q   <= 1'b0;
      ksel_q   <= '0;
      blk_q    <= '0;
      wdog_q   <= '0;
      mdata_q  <= '0;
      mlast_q  <= 1'b0;
      mvalid_q <= 1'b0;
      cnt_q    <= '0;
      err_q    <= '0;
      rdy_q    <= 1'b0;
    end else begin
      ctr_q    <= ctr_d;
      pt_q     <= pt_d;
      last_q   <= last_d;
      ksel_q   <= ksel_d;
      blk_q    <= blk_d;
      wdog_q   <= wdog_d;
      mdata_q  <= mdata_d;
      mlast_q  <= mlast_d;
      mvalid_q <= mvalid_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      rdy_q    <= rdy_d;
    end
  end

  // iv_load takes priority over data acceptance in the same cycle.
  assign s_ready      = rdy_q & ~iv_load;
  assign m_data       = mdata_q;
  assign m_valid      = mvalid_q;
  assign m_last       = mlast_q;
  assign core_start   = (state_q == ISSUE);
  assign core_block   = blk_q;
  assign core_key_sel = ksel_q;
  assign busy         = (state_q != IDLE);
  assign blk_count    = cnt_q;
  assign err          = err_q;

endmodule
